// File: rtl/alarm_pkg.sv
// alarm_pkg: state codes, parameter defaults and state width shared by the alarm controller.
package alarm_pkg;
  localparam int N_DOORS_DEF = 2;
  localparam int TICK_DIV_DEF = 100000000;
  localparam int CW_DEF = 4;
  localparam int SW = 2;
  typedef enum logic [SW-1:0] {
    ST_SET  = 2'd0,
    ST_OFF  = 2'd1,
    ST_TRIG = 2'd2,
    ST_ON   = 2'd3
  } state_e;
endpackage

// File: rtl/alarm_fsm_sec_tick.sv
// sec_tick: one-second prescaler emitting a single-cycle tick, restartable from 0.
module sec_tick
  import alarm_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);
  localparam int W = $clog2(TICK_DIV + 1);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == LAST;
  always_ff @(posedge clock)
    cnt_q <= (reset || restart_i || tick_o) ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/alarm_fsm.sv
// alarm_fsm: car alarm controller (SET/OFF/TRIGGER/ON) with per-door delays and one-second timer.
// Define ALARM_BLINK_EN to make the status LED blink at 0.5 Hz while armed.
module alarm_fsm
  import alarm_pkg::*;
#(
  parameter int N_DOORS  = N_DOORS_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ignition,
  input  logic [N_DOORS-1:0]    door,
  input  logic [N_DOORS*CW-1:0] door_delay,
  input  logic [CW-1:0]         arm_delay,
  input  logic [CW-1:0]         alarm_on_time,
  output logic                  status,
  output logic                  siren,
  output logic [SW-1:0]         state
);
  state_e state_q, state_d;
  logic [CW-1:0] timer_q, timer_d, trig_val, load_val;
  logic pend_q, pend_d, door0_q, tick, load, any_door, close_edge, expired;
  logic status_d, siren_d, set_status;

  sec_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock    (clock),
    .reset    (reset),
    .restart_i(load),
    .tick_o   (tick)
  );

  assign any_door = |door;
  assign expired = timer_q == '0;
  assign close_edge = door0_q && !door[0] && !ignition;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SET;
      timer_q <= '0;
      pend_q  <= 1'b0;
      door0_q <= 1'b0;
      state   <= ST_SET;
      status  <= 1'b0;
      siren   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      door0_q <= door[0];
      state   <= state_q;
      status  <= status_d;
      siren   <= siren_d;
    end
  end

  always_comb begin
    trig_val = '0;
    for (int i = N_DOORS - 1; i >= 0; i--)
      if (door[i]) trig_val = door_delay[i*CW +: CW];
    state_d = ignition ? ST_OFF :
              (state_q == ST_SET && any_door) ? ST_TRIG :
              (state_q == ST_TRIG && expired) ? ST_ON :
              (state_q == ST_ON && !any_door && expired) ? ST_SET :
              (state_q == ST_OFF && pend_q && !any_door && expired) ? ST_SET : state_q;
    // every load also restarts the prescaler so each count starts on a full second
    load = (state_d != state_q) || (state_d == ST_ON && any_door) || (state_d == ST_OFF && close_edge);
    load_val = state_d == ST_TRIG ? trig_val :
               state_d == ST_ON ? alarm_on_time :
               state_d == ST_OFF ? arm_delay : '0;
    timer_d = load ? load_val : (tick && !expired) ? timer_q - CW'(1) : timer_q;
    pend_d = state_q == ST_OFF && state_d == ST_OFF && !ignition && (close_edge || (pend_q && !any_door));
  end

`ifdef ALARM_BLINK_EN
  logic blink_q;
  always_ff @(posedge clock)
    blink_q <= (reset || state_q != ST_SET) ? 1'b0 : blink_q ^ tick;
  assign set_status = blink_q;
`else
  assign set_status = 1'b1;
`endif

  always_comb begin
    status_d = state_q == ST_OFF ? 1'b0 : state_q == ST_SET ? set_status : 1'b1;
    siren_d = state_q == ST_ON;
  end
endmodule

// File: tb/tb_alarm_fsm.sv
// tb_alarm_fsm: directed scenarios plus random traffic against a seconds-level reference model.
module tb_alarm_fsm;
  localparam int ND = 3, TD = 4, CW = 4;
  logic clock = 1'b0, rst = 1'b1, ignition = 1'b0, status, siren;
  logic [ND-1:0] door = '0;
  logic [ND*CW-1:0] door_delay = '0;
  logic [CW-1:0] arm_delay = '0, alarm_on_time = '0;
  logic [1:0] state;
  int n_checks = 0, n_errors = 0;
  int ms = 0, mload = 0, mp = 0, ost = 0, ostat = 0, osir = 0;
  bit mpend = 0, md0 = 0;

  always #5 clock = ~clock;

  alarm_fsm #(.N_DOORS(ND), .TICK_DIV(TD), .CW(CW)) dut (
    .clock(clock), .reset(rst), .ignition(ignition), .door(door),
    .door_delay(door_delay), .arm_delay(arm_delay), .alarm_on_time(alarm_on_time),
    .status(status), .siren(siren), .state(state)
  );

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mload = seconds loaded, mp = cycles since that load; whole seconds elapsed = mp/TD
  task automatic model_step();
    int nxt, val, i;
    bit any, zero, ce, rel;
    if (rst) begin
      ms = 0; mload = 0; mp = 0; mpend = 0; md0 = 0; ost = 0; ostat = 0; osir = 0;
      return;
    end
    ost = ms;
    osir = ms == 3;
`ifdef ALARM_BLINK_EN
    ostat = ms == 1 ? 0 : ms == 0 ? (mp / TD) % 2 : 1;
`else
    ostat = ms == 1 ? 0 : 1;
`endif
    any = |door;
    zero = mload <= mp / TD;
    ce = md0 && !door[0] && !ignition;
    nxt = ms;
    if (ignition) nxt = 1;
    else if (ms == 0 && any) nxt = 2;
    else if (ms == 2 && zero) nxt = 3;
    else if (ms == 3 && !any && zero) nxt = 0;
    else if (ms == 1 && mpend && !any && zero) nxt = 0;
    rel = nxt != ms || (nxt == 3 && any) || (nxt == 1 && ce);
    mpend = ms == 1 && nxt == 1 && !ignition && (ce || (mpend && !any));
    if (rel) begin
      val = 0;
      if (nxt == 2) begin
        i = 0;
        while (!door[i]) i++;
        val = int'(door_delay[i*CW +: CW]);
      end else if (nxt == 3) val = int'(alarm_on_time);
      else if (nxt == 1) val = int'(arm_delay);
      mload = val;
      mp = 0;
    end else mp++;
    md0 = door[0];
    ms = nxt;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check("state", int'(state), ost);
    check("status", int'(status), ostat);
    check("siren", int'(siren), osir);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  initial begin
    run(3);
    check("rst_state", int'(state), 0);
    check("rst_status", int'(status), 0);
    check("rst_siren", int'(siren), 0);
    rst = 1'b0;
    door_delay = {4'd7, 4'd2, 4'd5};
    alarm_on_time = 4'd3;
    arm_delay = 4'd2;
    run(2);
    door = 3'b010;
    run(2);
    check("trig_entry", int'(state), 2);
    run(10);
    check("on_state", int'(state), 3);
    check("on_siren", int'(siren), 1);
    door = 3'b001;
    run(20);
    door = 3'b000;
    run(10);
    check("on_hold", int'(state), 3);
    run(6);
    check("on_to_set", int'(state), 0);
    door = 3'b100;
    run(3);
    check("trig2", int'(state), 2);
    ignition = 1'b1;
    door = 3'b011;
    run(2);
    check("ign_state", int'(state), 1);
    check("ign_siren", int'(siren), 0);
    check("ign_status", int'(status), 0);
    door = 3'b000;
    run(2);
    ignition = 1'b0;
    run(2);
    door = 3'b001;
    run(2);
    door = 3'b000;
    run(6);
    check("arm_wait", int'(state), 1);
    run(6);
    check("armed", int'(state), 0);
    ignition = 1'b1;
    run(2);
    ignition = 1'b0;
    run(2);
    door = 3'b001;
    run(2);
    door = 3'b000;
    run(5);
    door = 3'b100;
    run(2);
    door = 3'b000;
    run(20);
    check("arm_abort", int'(state), 1);
    door = 3'b001;
    run(2);
    door = 3'b000;
    run(12);
    check("rearmed", int'(state), 0);
    door_delay = {4'd7, 4'd1, 4'd5};
    door = 3'b110;
    run(7);
    check("low_idx_on", int'(state), 3);
    door = 3'b000;
    run(20);
    check("back_set", int'(state), 0);
    door_delay = {4'd7, 4'd0, 4'd5};
    door = 3'b010;
    run(2);
    check("zero_trig", int'(state), 2);
    cyc();
    check("zero_on", int'(state), 3);
    door = 3'b000;
    run(20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(5);
`ifdef ALARM_BLINK_EN
    check("blink_hi", int'(status), 1);
    run(4);
    check("blink_lo", int'(status), 0);
`else
    check("set_led1", int'(status), 1);
    run(4);
    check("set_led2", int'(status), 1);
`endif
    door = 3'b001;
    run(3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    door = 3'b000;
    run(10);
    check("mid_rst", int'(state), 0);
    check("mid_rst_siren", int'(siren), 0);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 15) == 0) door = 3'($urandom);
      if ($urandom_range(0, 31) == 0) ignition = !ignition;
      if ($urandom_range(0, 63) == 0) begin
        door_delay = 12'($urandom) & 12'h333;
        arm_delay = 4'($urandom_range(0, 3));
        alarm_on_time = 4'($urandom_range(0, 3));
      end
      rst = $urandom_range(0, 499) == 0;
      cyc();
    end
    rst = 1'b0;
    run(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
